// File: rtl/tf_gen_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tf_gen_seq
//  Purpose  : Sequencer for the twiddle-factor generator. A start pulse
//             issues one seed-write cycle, then steps every stage (l) and
//             every iteration depth (it_depth_cnt), draining the modular
//             multiplier pipeline for MUL_LAT cycles after each stage, and
//             finally pulses done.
//  Ports    : clk          - clock, rising edge
//             rst          - asynchronous reset, active-low
//             start        - one-cycle request, honoured only in IDLE
//             stall        - downstream not ready, freezes RUN
//             TF_ren       - generator read enable
//             TF_wen       - generator write (seed load) enable
//             it_depth_cnt - current iteration depth
//             l            - current stage
//             idx_bus      - 15 lane indices, lane k at [4k-1:4k-4]
//             busy         - high from WRITE through DONE
//             done         - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module tf_gen_seq #(
    parameter int IT_DEPTH  = 3,
    parameter int NUM_STAGE = 5,
    parameter int MUL_LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    output logic        TF_ren,
    output logic        TF_wen,
    output logic [2:0]  it_depth_cnt,
    output logic [2:0]  l,
    output logic [59:0] idx_bus,
    output logic        busy,
    output logic        done
);

    localparam int c_DRAIN_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [2:0]           c_IT_LAST    = 3'(IT_DEPTH - 1);
    localparam logic [2:0]           c_L_LAST     = 3'(NUM_STAGE - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(MUL_LAT - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WRITE = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [2:0]           r_it;
    logic [2:0]           r_l;
    logic [3:0]           r_rot;
    logic [c_DRAIN_W-1:0] r_drain;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_next = c_ST_WRITE;
            c_ST_WRITE: w_next = c_ST_RUN;
            c_ST_RUN:   if (!stall && (r_it == c_IT_LAST)) w_next = c_ST_DRAIN;
            c_ST_DRAIN: begin
                if (r_drain == c_DRAIN_LAST) begin
                    w_next = (r_l == c_L_LAST) ? c_ST_DONE : c_ST_RUN;
                end
            end
            c_ST_DONE:  w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters: iteration depth, stage, rotation and drain length
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_it    <= 3'd0;
            r_l     <= 3'd0;
            r_rot   <= 4'd0;
            r_drain <= '0;
        end else begin
            case (r_state)
                c_ST_WRITE: begin
                    r_it <= 3'd0;
                    r_l  <= 3'd0;
                end
                c_ST_RUN: begin
                    if (!stall) begin
                        if (r_it == c_IT_LAST) begin
                            r_it    <= 3'd0;
                            r_drain <= '0;
                            // Lane rotation advances once per finished stage.
                            r_rot   <= (r_rot == 4'd14) ? 4'd0 : r_rot + 4'd1;
                        end else begin
                            r_it <= r_it + 3'd1;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (r_drain == c_DRAIN_LAST) begin
                        r_drain <= '0;
                        if (r_l != c_L_LAST) r_l <= r_l + 3'd1;
                    end else begin
                        r_drain <= r_drain + c_DRAIN_ONE;
                    end
                end
                c_ST_DONE: begin
                    // Stage and rotation restart from zero for the next run.
                    r_l   <= 3'd0;
                    r_rot <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. TF_ren is gated by stall in the same cycle so that a
    // stalled RUN cycle never issues a read.
    // ------------------------------------------------------------------
    assign TF_ren       = (r_state == c_ST_RUN) && !stall;
    assign TF_wen       = (r_state == c_ST_WRITE);
    assign busy         = (r_state != c_ST_IDLE);
    assign done         = (r_state == c_ST_DONE);
    assign it_depth_cnt = r_it;
    assign l            = r_l;

    // Lane k index = (k-1+rot) mod 15; the sum never exceeds 28, so a single
    // conditional subtract is enough.
    for (genvar k = 1; k <= 15; k++) begin : g_lane
        logic [4:0] w_sum;
        assign w_sum = 5'(k - 1) + {1'b0, r_rot};
        assign idx_bus[4*k-1 -: 4] = (w_sum >= 5'd15) ? 4'(w_sum - 5'd15) : w_sum[3:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_tf_gen_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tf_gen_seq
//  Purpose  : Self-checking bench for tf_gen_seq. Directed vectors with
//             hand-computed expectations for the default parameter set, plus
//             a second instance at IT_DEPTH=NUM_STAGE=MUL_LAT=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tf_gen_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_c;
    logic        stall;

    logic        TF_ren, TF_wen, busy, done;
    logic [2:0]  it_depth_cnt, l;
    logic [59:0] idx_bus;

    logic        TF_ren_c, TF_wen_c, busy_c, done_c;
    logic [2:0]  it_depth_cnt_c, l_c;
    logic [59:0] idx_bus_c;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    tf_gen_seq u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stall        (stall),
        .TF_ren       (TF_ren),
        .TF_wen       (TF_wen),
        .it_depth_cnt (it_depth_cnt),
        .l            (l),
        .idx_bus      (idx_bus),
        .busy         (busy),
        .done         (done)
    );

    tf_gen_seq #(.IT_DEPTH(1), .NUM_STAGE(1), .MUL_LAT(1)) u_dut_c (
        .clk          (clk),
        .rst          (rst),
        .start        (start_c),
        .stall        (stall),
        .TF_ren       (TF_ren_c),
        .TF_wen       (TF_wen_c),
        .it_depth_cnt (it_depth_cnt_c),
        .l            (l_c),
        .idx_bus      (idx_bus_c),
        .busy         (busy_c),
        .done         (done_c)
    );

    // cn: cycle in an unstalled run, cs: cycle in the run with a RUN stall
    // at cycle 3 (and an ignored DRAIN stall at cycle 7); -1 = not checked.
    typedef struct {
        int         cn;
        int         cs;
        logic       ren;
        logic       wen;
        logic [2:0] it;
        logic [2:0] st;
        logic       bsy;
        logic       dn;
        logic [3:0] ln1;
        logic [3:0] ln15;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] pack_act();
        return {TF_ren, TF_wen, it_depth_cnt, l, busy, done, idx_bus[3:0], idx_bus[59:56]};
    endfunction

    function automatic logic [17:0] pack_exp(input vec_t v);
        return {v.ren, v.wen, v.it, v.st, v.bsy, v.dn, v.ln1, v.ln15};
    endfunction

    // One full run from a start pulse; cycle 1 is the cycle after the edge
    // that samples start.
    task automatic run_seq(input bit stalled, input int restart_cyc, input string tag);
        int done_cyc;
        done_cyc = stalled ? 33 : 32;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            stall = stalled && (c == 3 || c == 7);
            start = (c == restart_cyc);
            #1;
            foreach (tbl[i]) begin
                if ((stalled ? tbl[i].cs : tbl[i].cn) == c)
                    chk($sformatf("%s cyc%0d", tag, c), 64'(pack_act()), 64'(pack_exp(tbl[i])));
            end
            chk($sformatf("%s done_pos cyc%0d", tag, c), 64'(done), 64'(c == done_cyc));
            chk($sformatf("%s ren_wen_excl cyc%0d", tag, c), 64'(TF_ren & TF_wen), 64'(0));
            tick();
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    logic [59:0] idx_rst;

    initial begin
        //            cn  cs ren wen it st bsy dn ln1 ln15
        tbl.push_back('{ 1,  1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 4'd0, 4'd14});
        tbl.push_back('{ 2,  2, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 4'd0, 4'd14});
        tbl.push_back('{-1,  3, 1'b0, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0, 4'd0, 4'd14});
        tbl.push_back('{ 3,  4, 1'b1, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0, 4'd0, 4'd14});
        tbl.push_back('{ 4,  5, 1'b1, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0, 4'd0, 4'd14});
        tbl.push_back('{ 5,  6, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 4'd1, 4'd0});
        tbl.push_back('{ 7,  8, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 4'd1, 4'd0});
        tbl.push_back('{ 8,  9, 1'b1, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 4'd1, 4'd0});
        tbl.push_back('{10, 11, 1'b1, 1'b0, 3'd2, 3'd1, 1'b1, 1'b0, 4'd1, 4'd0});
        tbl.push_back('{11, 12, 1'b0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 4'd2, 4'd1});
        tbl.push_back('{26, 27, 1'b1, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 4'd4, 4'd3});
        tbl.push_back('{28, 29, 1'b1, 1'b0, 3'd2, 3'd4, 1'b1, 1'b0, 4'd4, 4'd3});
        tbl.push_back('{29, 30, 1'b0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 4'd5, 4'd4});
        tbl.push_back('{31, 32, 1'b0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 4'd5, 4'd4});
        tbl.push_back('{32, 33, 1'b0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b1, 4'd5, 4'd4});
        tbl.push_back('{33, 34, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd0, 4'd14});
        tbl.push_back('{34, 35, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd0, 4'd14});

        for (int k = 1; k <= 15; k++) idx_rst[4*k-1 -: 4] = 4'(k - 1);

        // ---------------- reset values ----------------
        rst     = 1'b0;
        start   = 1'b0;
        start_c = 1'b0;
        stall   = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("reset ctl", 64'({TF_ren, TF_wen, it_depth_cnt, l, busy, done}), 64'(0));
        chk("reset idx", 64'(idx_bus), 64'(idx_rst));
        chk("reset corner", 64'({TF_ren_c, TF_wen_c, busy_c, done_c, idx_bus_c == idx_rst}), 64'(1));

        // ---------------- three back-to-back runs, reset only before first ----------------
        run_seq(1'b0, 0,  "run1");
        run_seq(1'b0, 10, "run2_restart10");
        run_seq(1'b0, 32, "run3_start_in_done");

        // ---------------- stall in RUN (cycle 3) and DRAIN (cycle 7) ----------------
        run_seq(1'b1, 0, "stall");

        // ---------------- mid-run reset at cycle 12 ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        chk("midrst pre busy_l", 64'({busy, l}), 64'({1'b1, 3'd1}));
        rst = 1'b0;
        #1;
        chk("midrst async ctl", 64'({TF_ren, TF_wen, it_depth_cnt, l, busy, done}), 64'(0));
        chk("midrst async idx", 64'(idx_bus), 64'(idx_rst));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("midrst held %0d", c), 64'({busy, done}), 64'(0));
        end
        rst = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            chk($sformatf("midrst no_done %0d", c), 64'({busy, done}), 64'(0));
        end
        run_seq(1'b0, 0, "after_rst");

        // ---------------- parameter corner 1/1/1 ----------------
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        begin
            logic [3:0] exp_c [5];
            exp_c[0] = 4'b0110;  // {ren,wen,busy,done}: WRITE
            exp_c[1] = 4'b1010;  // RUN
            exp_c[2] = 4'b0010;  // DRAIN
            exp_c[3] = 4'b0011;  // DONE
            exp_c[4] = 4'b0000;  // IDLE
            for (int c = 0; c < 5; c++) begin
                chk($sformatf("corner cyc%0d", c + 1),
                    64'({TF_ren_c, TF_wen_c, busy_c, done_c, it_depth_cnt_c, l_c}),
                    64'({exp_c[c], 3'd0, 3'd0}));
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
`default_nettype wire
